// File: rtl/sram_dac_player_if.sv
// sram_dac_player_if: SRAM read port between the playback engine and the SRAM.
//   SRAM_ADDR  read word address                          (master -> slave)
//   SRAM_OE_N  output enable, active low                  (master -> slave)
//   SRAM_DQ    read data, valid one cycle after ADDR/OE   (slave -> master)
interface sram_dac_player_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 20
);
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_OE_N;
    logic [DATA_W-1:0] SRAM_DQ;

    modport master (output SRAM_ADDR, output SRAM_OE_N, input SRAM_DQ);
    modport slave  (input SRAM_ADDR, input SRAM_OE_N, output SRAM_DQ);
endinterface

// File: rtl/sram_dac_player.sv
// sram_dac_player: reads 16-bit mono samples from SRAM between a start and end address,
// applies fast (skip N) or slow (hold / linear interpolation over N frames) playback and
// serializes each sample MSB first onto DACDAT, I2S-style, in both LRCK halves.
// Ports:
//   i_clk, i_rst        BCLK and asynchronous active-high reset
//   i_play              level, 1 = run, 0 = stop at once
//   i_start_pos/end_pos inclusive address range, latched on play start
//   i_speed             [3] slow, [2:0] N-1;  i_intpol selects interpolation in slow mode
//   i_DACLRCK           codec frame clock, 0 = left half
//   sram                SRAM read port (address, output enable, data)
//   o_DACDAT            serial sample;  o_pos current address;  o_done end-of-range pulse
module sram_dac_player #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_play,
    input  logic [ADDR_W-1:0] i_start_pos,
    input  logic [ADDR_W-1:0] i_end_pos,
    input  logic [3:0]        i_speed,
    input  logic              i_intpol,
    input  logic              i_DACLRCK,
    sram_dac_player_if.master sram,
    output logic              o_DACDAT,
    output logic [ADDR_W-1:0] o_pos,
    output logic              o_done
);
    localparam int unsigned PW = DATA_W + 24;
    localparam logic signed [PW-1:0] SMAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD0, S_RD1, S_RD2, S_CALC} state_t;

    state_t            state_q;
    logic              lrck_d;
    logic [ADDR_W-1:0] pos_q, end_q, addr_q;
    logic [2:0]        k_q, n_q;
    logic              slow_q, oe_n_q, done_q;
    logic              finish_q;  // range exhausted, leave at the next frame edge
    logic              halted_q;  // finished, wait for i_play to drop before restarting
    logic [DATA_W-1:0] cur_q, nxt_q, out_q, held_q, shift_q;

    // 1/N in 0.16 fixed point for N = 1..8
    function automatic logic [16:0] recip(input logic [2:0] nm1);
        case (nm1)
            3'd0:    return 17'd65536;
            3'd1:    return 17'd32768;
            3'd2:    return 17'd21845;
            3'd3:    return 17'd16384;
            3'd4:    return 17'd13107;
            3'd5:    return 17'd10923;
            3'd6:    return 17'd9362;
            default: return 17'd8192;
        endcase
    endfunction

    logic fall_edge, rise_edge;
    assign fall_edge = lrck_d & ~i_DACLRCK;
    assign rise_edge = ~lrck_d & i_DACLRCK;

    // Linear interpolation: cur + floor(diff * k / N), saturated
    logic signed [DATA_W-1:0] cur_s, nxt_s;
    logic signed [DATA_W:0]   diff;
    logic signed [PW-1:0]     diff_w, k_w, r_w, prod, sum;
    logic [DATA_W-1:0]        interp_out, calc_out;
    assign cur_s  = cur_q;
    assign nxt_s  = nxt_q;
    assign diff   = (DATA_W+1)'(nxt_s) - (DATA_W+1)'(cur_s);
    assign diff_w = PW'(diff);
    assign k_w    = PW'(k_q);
    assign r_w    = PW'(recip(n_q));
    assign prod   = diff_w * k_w * r_w;
    assign sum    = PW'(cur_s) + (prod >>> 16);
    assign interp_out = (sum > SMAX) ? SMAX[DATA_W-1:0] :
                        (sum < SMIN) ? SMIN[DATA_W-1:0] : sum[DATA_W-1:0];
    assign calc_out = (slow_q && i_intpol) ? interp_out : cur_q;

    // Position arithmetic one bit wider so the end test never wraps
    logic [ADDR_W:0] pos_p1, pos_fast, pos_new, end_ext;
    logic [3:0]      k_next, n_val;
    logic            slow_wrap, past_end;
    assign end_ext   = {1'b0, end_q};
    assign pos_p1    = {1'b0, pos_q} + (ADDR_W+1)'(1);
    assign pos_fast  = {1'b0, pos_q} + (ADDR_W+1)'(n_q) + (ADDR_W+1)'(1);
    assign k_next    = {1'b0, k_q} + 4'd1;
    assign n_val     = {1'b0, n_q} + 4'd1;
    assign slow_wrap = (k_next == n_val);
    assign pos_new   = !slow_q ? pos_fast : (slow_wrap ? pos_p1 : {1'b0, pos_q});
    assign past_end  = (pos_new > end_ext);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            lrck_d   <= 1'b0;
            pos_q    <= '0;
            end_q    <= '0;
            addr_q   <= '0;
            k_q      <= '0;
            n_q      <= '0;
            slow_q   <= 1'b0;
            oe_n_q   <= 1'b1;
            done_q   <= 1'b0;
            finish_q <= 1'b0;
            halted_q <= 1'b0;
            cur_q    <= '0;
            nxt_q    <= '0;
            out_q    <= '0;
            held_q   <= '0;
            shift_q  <= '0;
        end else begin
            lrck_d  <= i_DACLRCK;
            done_q  <= 1'b0;
            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            if (!i_play) begin
                state_q  <= S_IDLE;
                oe_n_q   <= 1'b1;
                shift_q  <= '0;
                finish_q <= 1'b0;
                halted_q <= 1'b0;
            end else begin
                // Left half latches the sample; right half replays the same one
                if (state_q != S_IDLE) begin
                    if (fall_edge) begin
                        shift_q <= out_q;
                        held_q  <= out_q;
                    end else if (rise_edge) begin
                        shift_q <= held_q;
                    end
                end
                case (state_q)
                    S_IDLE: begin
                        if (!halted_q) begin
                            if (i_start_pos > i_end_pos) begin
                                done_q   <= 1'b1;
                                halted_q <= 1'b1;
                            end else begin
                                pos_q    <= i_start_pos;
                                end_q    <= i_end_pos;
                                k_q      <= '0;
                                out_q    <= '0;
                                finish_q <= 1'b0;
                                state_q  <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (fall_edge) begin
                            if (finish_q) begin
                                finish_q <= 1'b0;
                                halted_q <= 1'b1;
                                state_q  <= S_IDLE;
                            end else begin
                                n_q     <= i_speed[2:0];
                                slow_q  <= i_speed[3];
                                if (i_speed[2:0] != n_q) k_q <= '0;
                                addr_q  <= pos_q;
                                oe_n_q  <= 1'b0;
                                state_q <= S_RD0;
                            end
                        end
                    end
                    S_RD0: begin
                        addr_q  <= pos_p1[ADDR_W-1:0];
                        state_q <= S_RD1;
                    end
                    S_RD1: begin
                        cur_q   <= sram.SRAM_DQ;
                        state_q <= S_RD2;
                    end
                    S_RD2: begin
                        // Past the end there is no next sample: interpolate towards cur
                        nxt_q   <= (pos_p1 > end_ext) ? cur_q : sram.SRAM_DQ;
                        oe_n_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                    S_CALC: begin
                        out_q <= calc_out;
                        pos_q <= pos_new[ADDR_W-1:0];
                        if (slow_q) k_q <= slow_wrap ? 3'd0 : k_next[2:0];
                        if (past_end) begin
                            done_q   <= 1'b1;
                            finish_q <= 1'b1;
                        end
                        state_q <= S_WAIT;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign sram.SRAM_ADDR = addr_q;
    assign sram.SRAM_OE_N = oe_n_q;
    assign o_DACDAT       = shift_q[DATA_W-1];
    assign o_pos          = pos_q;
    assign o_done         = done_q;
endmodule
